// File: rtl/ni_fifo_write_arbiter_if.sv
// Requester-side and NI FIFO write-side signal bundle of the FIFO write arbiter.
// slave = arbiter view, master = requesters/FIFO view.
interface ni_fifo_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic               fifo_full;
  logic [NREQ-1:0]    flit_ack;
  logic [NREQ-1:0]    pkt_done;
  logic [NREQ-1:0]    grant;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_data;
  logic               busy;

  modport slave (
    input  req, req_data, fifo_full,
    output flit_ack, pkt_done, grant, fifo_wr, fifo_data, busy
  );

  modport master (
    output req, req_data, fifo_full,
    input  flit_ack, pkt_done, grant, fifo_wr, fifo_data, busy
  );
endinterface

// File: rtl/ni_fifo_write_arbiter.sv
// Round-robin, packet-atomic arbiter sharing the NI FIFO write port among NREQ requesters.
// Optional: define NI_ARB_PRIORITY_EN to give requester 0 absolute priority in IDLE.
module ni_fifo_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int PKT_LEN = 2
) (
  input  logic                  clk_division,
  input  logic                  rst,
  input  logic                  enable,
  ni_fifo_write_arbiter_if.slave bus
);
  localparam int              PW        = $clog2(NREQ);
  localparam logic [7:0]      LAST_FLIT = 8'(PKT_LEN - 1);
  localparam logic [PW-1:0]   LAST_REQ  = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_next;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   winner, rr_ptr, rr_next, pick_idx, scan_idx;
  logic [7:0]      flit_cnt;
  logic            pick_valid, last_flit, wr;

  // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (bus.req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
`ifdef NI_ARB_PRIORITY_EN
    if (bus.req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  assign rr_next = (winner == LAST_REQ) ? '0 : winner + 1'b1;

  always_ff @(posedge clk_division) begin
    if (rst || !enable) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = XFER;
      XFER:    if (last_flit)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // enable low abandons the packet but keeps rr_ptr; only rst clears the pointer.
  always_ff @(posedge clk_division) begin
    if (rst) begin
      grant    <= '0;
      winner   <= '0;
      flit_cnt <= '0;
      rr_ptr   <= '0;
    end else if (!enable) begin
      grant    <= '0;
      flit_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_valid) begin
        grant    <= ONE_HOT0 << pick_idx;
        winner   <= pick_idx;
        flit_cnt <= '0;
      end
    end else if (wr) begin
      flit_cnt <= flit_cnt + 8'd1;
      if (last_flit) begin
        grant <= '0;
`ifdef NI_ARB_PRIORITY_EN
        if (winner != '0) rr_ptr <= rr_next;
`else
        rr_ptr <= rr_next;
`endif
      end
    end
  end

  always_comb begin
    wr            = (state == XFER) && enable && !bus.fifo_full;
    last_flit     = wr && (flit_cnt == LAST_FLIT);
    bus.fifo_wr   = wr;
    bus.fifo_data = (state == XFER) ? bus.req_data[winner*DW +: DW] : '0;
    bus.flit_ack  = grant & {NREQ{wr}};
    bus.pkt_done  = last_flit ? grant : '0;
    bus.grant     = grant;
    bus.busy      = (state == XFER);
  end
endmodule

// File: doc/ni_fifo_write_arbiter.md
# ni_fifo_write_arbiter

Shares the single write port of the regular NI FIFO between NREQ sensor packet generators. Grants one requester at a time in round-robin order, holds the grant for a whole fixed-length packet so flits of different packets never interleave, and stalls on FIFO full. Sits between the per-core sample/packet generators and the NI FIFO write side, clocked by the divided clock.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 16, flit width
- PKT_LEN, 2, flits per packet (head flit + data flit); 1..255

Ports:
- clk_division  in  1  divided clock; all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- enable  in  1  block enable; low behaves as a synchronous soft reset
- req  in  NREQ  per-requester packet request; level, held until last flit acked
- req_data  in  NREQ*DW  flit presented by requester i on bits [i*DW +: DW]
- fifo_full  in  1  NI FIFO full
- flit_ack  out  NREQ  one-hot; requester i's current flit was written this cycle, advance to next
- pkt_done  out  NREQ  one-hot pulse with the last flit_ack of a packet
- grant  out  NREQ  one-hot registered grant; zero when idle
- fifo_wr  out  1  NI FIFO write strobe
- fifo_data  out  DW  NI FIFO write data
- busy  out  1  high while in XFER

## Operation
- States: IDLE, XFER. Reset/enable-low state IDLE.
- IDLE: grant=0. If enable and req!=0, pick winner = first asserted req at or after rr_ptr, scanning upward modulo NREQ; register grant=onehot(winner), flit_cnt=0, go XFER. Else stay.
- XFER: fifo_wr = enable & ~fifo_full (combinational). fifo_data = req_data slice of granted requester whenever in XFER, else 0. flit_ack = grant & {NREQ{fifo_wr}}.
- flit_cnt (8 bit) increments on each fifo_wr. When fifo_wr and flit_cnt==PKT_LEN-1: pkt_done=grant, rr_ptr = winner+1 mod NREQ, grant cleared, go IDLE.
- req is not sampled in XFER; deasserting req mid-packet does not abort; requester must keep valid data until its pkt_done.
- rr_ptr width clog2(NREQ), reset 0; wraps from NREQ-1 to 0.
- fifo_full in XFER: fifo_wr=0, flit_cnt holds, grant holds; no timeout.
- rst or enable low in any state: next cycle state=IDLE, grant=0, flit_cnt=0, rr_ptr=0 (rst only; enable low keeps rr_ptr); partial packet abandoned, no pkt_done.
- Reset values: grant=0, busy=0, fifo_wr=0, fifo_data=0, flit_ack=0, pkt_done=0.

## Timing
- req sampled in IDLE at edge N -> grant/busy high from cycle N+1, first fifo_wr in cycle N+1 if not full.
- Packet with no stalls occupies PKT_LEN cycles in XFER; one mandatory IDLE bubble between packets, so back-to-back throughput is PKT_LEN per PKT_LEN+1 cycles.
- flit_ack, pkt_done, fifo_wr are same-cycle combinational outputs of registered state and fifo_full; fifo_full has combinational path to fifo_wr.
- Simultaneous requests: resolved only in IDLE by rr_ptr; a request arriving during XFER waits at most (NREQ-1) packets.

## Configuration
- NI_ARB_PRIORITY_EN defined: requester 0 (alarm/event source) wins in IDLE whenever req[0] is high, regardless of rr_ptr; rr_ptr is not updated after a requester-0 packet; other requesters round-robin among themselves.
- Not defined: pure round-robin across all NREQ requesters, requester 0 has no privilege.

## Test plan
- Single req[2], data 0x002F then 0xC005, PKT_LEN=2, no full -> grant=0100 one cycle later, fifo_wr 2 cycles writing 0x002F,0xC005, pkt_done[2] on 2nd, busy low next cycle.
- All req high from reset, 3 packets each -> grant order 0,1,2,3,0,1,..., one IDLE cycle between packets, no interleaved flits in FIFO.
- fifo_full high for 3 cycles after first flit -> fifo_wr=0 and flit_ack=0 for 3 cycles, grant held, second flit written on the cycle full drops, total packet 5 cycles.
- enable dropped after first flit of requester 1 -> next cycle IDLE, grant=0, no pkt_done; on re-enable with req[1] still high, requester 1 regranted with flit_cnt=0.
- rst asserted mid-packet with rr_ptr=3 -> all outputs 0 next cycle, rr_ptr=0, next grant to lowest asserted req.
- With NI_ARB_PRIORITY_EN, req[0] and req[1] continuously high -> requester 0 granted every packet; without macro -> alternates 0,1.
